// File: rtl/bonus_collector_pkg.sv
// rtl/bonus_collector_pkg.sv - shared tuning constants for the bullet-supply pickup logic
package bonus_collector_pkg;
  localparam int BONUS_OVERLAP_MIN     = 4;
  localparam int BONUS_COOLDOWN_FRAMES = 30;
  localparam int BONUS_LEVEL_MAX       = 3;
  localparam int BONUS_LEVEL_FRAMES    = 600;
endpackage

// File: rtl/bonus_collector_level_timer.sv
// rtl/bonus_collector_level_timer.sv - saturating bullet upgrade level with per-level frame timer
module bonus_level_timer #(
  parameter int LEVEL_MAX      = 3,
  parameter int LEVEL_BITS     = 2,
  parameter int LEVEL_FRAMES   = 600,
  parameter int FRAME_CNT_BITS = 10
) (
  input  logic                  clk_vga,
  input  logic                  rst,
  input  logic                  en_i,
  input  logic                  pickup_i,
  input  logic                  frame_i,
  output logic [LEVEL_BITS-1:0] level_o,
  output logic                  active_o
);
  logic [LEVEL_BITS-1:0]     level_q, level_d;
  logic [FRAME_CNT_BITS-1:0] timer_q, timer_d;
  logic                      active_q;

  // A pickup in the same cycle as a frame boundary takes priority and skips the decay step.
  always_comb begin
    level_d = level_q;
    timer_d = timer_q;
    if (en_i) begin
      if (pickup_i) begin
        if (level_q < LEVEL_BITS'(LEVEL_MAX)) level_d = level_q + 1'b1;
        timer_d = FRAME_CNT_BITS'(LEVEL_FRAMES);
      end else if (frame_i && (level_q != '0)) begin
        if (timer_q <= FRAME_CNT_BITS'(1)) begin
          level_d = level_q - 1'b1;
          timer_d = (level_q > LEVEL_BITS'(1)) ? FRAME_CNT_BITS'(LEVEL_FRAMES) : '0;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_vga or posedge rst) begin
    if (rst) begin
      level_q  <= '0;
      timer_q  <= '0;
      active_q <= 1'b0;
    end else begin
      level_q  <= level_d;
      timer_q  <= timer_d;
      active_q <= (level_d != '0);
    end
  end

  assign level_o  = level_q;
  assign active_o = active_q;
endmodule

// File: rtl/bonus_collector.sv
// rtl/bonus_collector.sv - player/bullet-supply overlap detector, pickup strobe and upgrade level
module bonus_collector
  import bonus_collector_pkg::*;
#(
  parameter int OVERLAP_MIN     = BONUS_OVERLAP_MIN,
  parameter int COOLDOWN_FRAMES = BONUS_COOLDOWN_FRAMES,
  parameter int LEVEL_MAX       = BONUS_LEVEL_MAX,
  parameter int LEVEL_BITS      = 2,
  parameter int LEVEL_FRAMES    = BONUS_LEVEL_FRAMES,
  parameter int FRAME_CNT_BITS  = 10
) (
  input  logic                  clk_vga,
  input  logic                  rst,
  input  logic                  en_i,
  input  logic                  v_sync_i,
  input  logic                  me_alpha_i,
  input  logic                  bonus_alpha_i,
  output logic                  crash_me_bonus_o,
  output logic                  pickup_o,
  output logic [LEVEL_BITS-1:0] bullet_level_o,
  output logic                  upgrade_active_o
);
  localparam int OvBits = $clog2(OVERLAP_MIN + 1);

  typedef enum logic [1:0] {ST_ARMED, ST_HIT, ST_COOLDOWN} state_e;

  state_e                    state_q, state_d;
  logic [OvBits-1:0]         ov_cnt_q, ov_cnt_d;
  logic [FRAME_CNT_BITS-1:0] cd_cnt_q, cd_cnt_d;
  logic                      crash_q, crash_d;
  logic                      pickup_q, pickup_d;
  logic                      vs_q;
  logic                      vs_edge, overlap;

  assign vs_edge = v_sync_i & ~vs_q;
  assign overlap = en_i & me_alpha_i & bonus_alpha_i & ~vs_edge;

  always_comb begin
    state_d  = state_q;
    ov_cnt_d = ov_cnt_q;
    cd_cnt_d = cd_cnt_q;
    crash_d  = 1'b0;
    pickup_d = 1'b0;
    if (en_i) begin
      unique case (state_q)
        ST_ARMED: begin
          if (vs_edge) begin
            ov_cnt_d = '0;
          end else if (overlap) begin
            if (ov_cnt_q != OvBits'(OVERLAP_MIN)) ov_cnt_d = ov_cnt_q + 1'b1;
            if (ov_cnt_q >= OvBits'(OVERLAP_MIN - 1)) begin
              state_d  = ST_HIT;
              crash_d  = 1'b1;
              pickup_d = 1'b1;
            end
          end
        end
        ST_HIT: begin
          crash_d = overlap;
          if (vs_edge) begin
            ov_cnt_d = '0;
            if (COOLDOWN_FRAMES == 0) begin
              state_d = ST_ARMED;
            end else begin
              cd_cnt_d = FRAME_CNT_BITS'(COOLDOWN_FRAMES);
              state_d  = ST_COOLDOWN;
            end
          end
        end
        ST_COOLDOWN: begin
          if (vs_edge) begin
            if (cd_cnt_q <= FRAME_CNT_BITS'(1)) begin
              cd_cnt_d = '0;
              state_d  = ST_ARMED;
            end else begin
              cd_cnt_d = cd_cnt_q - 1'b1;
            end
          end
        end
        default: state_d = ST_ARMED;
      endcase
    end
  end

  always_ff @(posedge clk_vga or posedge rst) begin
    if (rst) begin
      state_q  <= ST_ARMED;
      ov_cnt_q <= '0;
      cd_cnt_q <= '0;
      crash_q  <= 1'b0;
      pickup_q <= 1'b0;
      vs_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      ov_cnt_q <= ov_cnt_d;
      cd_cnt_q <= cd_cnt_d;
      crash_q  <= crash_d;
      pickup_q <= pickup_d;
      vs_q     <= v_sync_i;
    end
  end

  // Level reacts to the registered pickup, so it lands one cycle after pickup_o.
  bonus_level_timer #(
    .LEVEL_MAX     (LEVEL_MAX),
    .LEVEL_BITS    (LEVEL_BITS),
    .LEVEL_FRAMES  (LEVEL_FRAMES),
    .FRAME_CNT_BITS(FRAME_CNT_BITS)
  ) u_level (
    .clk_vga (clk_vga),
    .rst     (rst),
    .en_i    (en_i),
    .pickup_i(pickup_q),
    .frame_i (vs_edge),
    .level_o (bullet_level_o),
    .active_o(upgrade_active_o)
  );

  assign crash_me_bonus_o = crash_q;
  assign pickup_o         = pickup_q;
endmodule

// File: tb/tb_bonus_collector.sv
// tb/tb_bonus_collector.sv - self-checking bench for bonus_collector against a frame-level model
module tb_bonus_collector;
  localparam int OV_MIN = 4;
  localparam int COOL   = 30;
  localparam int LMAX   = 3;
  localparam int LFR    = 600;

  logic       clk_vga = 1'b0;
  logic       rst = 1'b1;
  logic       en_i = 1'b1;
  logic       v_sync_i = 1'b0;
  logic       me_alpha_i = 1'b0;
  logic       bonus_alpha_i = 1'b0;
  logic       crash_me_bonus_o, pickup_o, upgrade_active_o;
  logic [1:0] bullet_level_o;

  int n_cmp = 0, n_bad = 0;
  int n_pick = 0, n_crash = 0;
  int p0, c0;

  always #5 clk_vga = ~clk_vga;

  bonus_collector dut (
    .clk_vga         (clk_vga),
    .rst             (rst),
    .en_i            (en_i),
    .v_sync_i        (v_sync_i),
    .me_alpha_i      (me_alpha_i),
    .bonus_alpha_i   (bonus_alpha_i),
    .crash_me_bonus_o(crash_me_bonus_o),
    .pickup_o        (pickup_o),
    .bullet_level_o  (bullet_level_o),
    .upgrade_active_o(upgrade_active_o)
  );

  // Frame-level model: overlap pixels counted per frame, frames of cooldown left, level and frames left.
  int m_count = 0, m_cool = 0, m_level = 0, m_left = 0;
  bit m_got = 0, m_prev_vs = 0, e_crash = 0, e_pick = 0;
  bit m_edge, m_pk;

  always @(posedge clk_vga or posedge rst) begin
    if (rst) begin
      m_count = 0; m_cool = 0; m_level = 0; m_left = 0;
      m_got = 0; m_prev_vs = 0; e_crash = 0; e_pick = 0;
    end else begin
      m_edge = v_sync_i && !m_prev_vs;
      m_prev_vs = v_sync_i;
      if (!en_i) begin
        e_crash = 0;
        e_pick = 0;
      end else begin
        m_pk = e_pick;
        e_pick = 0;
        e_crash = 0;
        if (m_pk) begin
          m_level = (m_level + 1 > LMAX) ? LMAX : m_level + 1;
          m_left = LFR;
        end else if (m_edge && m_level > 0) begin
          m_left = m_left - 1;
          if (m_left == 0) begin
            m_level = m_level - 1;
            if (m_level > 0) m_left = LFR;
          end
        end
        if (m_edge) begin
          if (m_got) begin
            m_got = 0;
            m_cool = COOL;
          end else if (m_cool > 0) begin
            m_cool = m_cool - 1;
          end
          m_count = 0;
        end else if (me_alpha_i && bonus_alpha_i) begin
          if (m_got) begin
            e_crash = 1;
          end else if (m_cool == 0) begin
            m_count = m_count + 1;
            if (m_count >= OV_MIN) begin
              m_got = 1;
              e_pick = 1;
              e_crash = 1;
            end
          end
        end
      end
    end
  end

  logic [4:0] exp_vec, act_vec;
  always @(negedge clk_vga) begin
    if (!rst) begin
      exp_vec = {e_crash, e_pick, 2'(m_level), (m_level != 0)};
      act_vec = {crash_me_bonus_o, pickup_o, bullet_level_o, upgrade_active_o};
      n_cmp++;
      if (act_vec !== exp_vec) begin
        n_bad++;
        $display("FAIL cycle_outputs t=%0t {crash,pickup,level,active} got %b want %b", $time, act_vec, exp_vec);
      end
      if (pickup_o === 1'b1) n_pick++;
      if (crash_me_bonus_o === 1'b1) n_crash++;
    end
  end

  task automatic check(input string name, input int got, input int want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic cyc(input bit vs, input bit me, input bit bo);
    v_sync_i = vs;
    me_alpha_i = me;
    bonus_alpha_i = bo;
    @(negedge clk_vga);
  endtask

  task automatic frame(input int ov, input int tail);
    cyc(1, 0, 0);
    cyc(0, 0, 0);
    for (int i = 0; i < ov; i++) cyc(0, 1, 1);
    for (int i = 0; i < tail; i++) cyc(0, 0, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk_vga);
    check("reset_outputs", int'({crash_me_bonus_o, pickup_o, bullet_level_o, upgrade_active_o}), 0);
    rst = 1'b0;

    repeat (100) frame(0, 2);
    check("idle_pickups", n_pick, 0);
    check("idle_level", int'(bullet_level_o), 0);

    frame(3, 2);
    frame(3, 2);
    cyc(1, 0, 0);
    for (int i = 0; i < 6; i++) cyc(0, 1, 0);
    for (int i = 0; i < 6; i++) cyc(0, 0, 1);
    cyc(0, 0, 0);
    check("split_frames_crash", n_crash, 0);
    check("split_frames_pickup", n_pick, 0);

    p0 = n_pick; c0 = n_crash;
    frame(6, 2);
    check("first_pickup_pulses", n_pick - p0, 1);
    check("first_pickup_crash_cycles", n_crash - c0, 3);
    check("first_pickup_level", int'(bullet_level_o), 1);

    p0 = n_pick; c0 = n_crash;
    repeat (COOL) frame(6, 2);
    check("cooldown_crash", n_crash - c0, 0);
    frame(6, 2);
    check("second_pickup_pulses", n_pick - p0, 1);
    check("second_pickup_level", int'(bullet_level_o), 2);

    repeat (COOL) frame(0, 2);
    frame(6, 2);
    check("third_pickup_level", int'(bullet_level_o), 3);
    repeat (COOL) frame(0, 2);
    frame(6, 2);
    check("saturated_level", int'(bullet_level_o), 3);
    check("fourth_active", int'(upgrade_active_o), 1);

    p0 = n_pick; c0 = n_crash;
    repeat (10) frame(0, 2);
    en_i = 1'b0;
    repeat (50) frame(6, 2);
    en_i = 1'b1;
    repeat (20) frame(6, 2);
    check("frozen_cooldown_crash", n_crash - c0, 0);
    frame(4, 0);
    frame(0, 2);
    check("coincident_pickup", n_pick - p0, 1);

    repeat (LFR - 1) frame(0, 2);
    check("no_decay_on_pickup_edge", int'(bullet_level_o), 3);
    frame(0, 2);
    check("decay_to_2", int'(bullet_level_o), 2);
    repeat (LFR - 1) frame(0, 2);
    check("hold_2", int'(bullet_level_o), 2);
    frame(0, 2);
    check("decay_to_1", int'(bullet_level_o), 1);
    repeat (300) frame(0, 2);
    en_i = 1'b0;
    repeat (50) frame(0, 2);
    en_i = 1'b1;
    repeat (LFR - 301) frame(0, 2);
    check("timer_frozen_hold_1", int'(bullet_level_o), 1);
    frame(0, 2);
    check("decay_to_0", int'(bullet_level_o), 0);
    check("active_fall", int'(upgrade_active_o), 0);

    frame(6, 2);
    repeat (5) frame(0, 2);
    cyc(0, 0, 0);
    rst = 1'b1;
    cyc(0, 0, 0);
    check("midcool_reset_level", int'(bullet_level_o), 0);
    check("midcool_reset_crash", int'(crash_me_bonus_o), 0);
    rst = 1'b0;
    p0 = n_pick;
    frame(6, 2);
    check("pickup_after_reset", n_pick - p0, 1);
    check("level_after_reset", int'(bullet_level_o), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
